ifu: RTL and testbench

Instruction fetch unit: owns the architectural fetch PC and issues one instruction-memory read at a time over a valid/ready request/response pair. It runs each returned word through the `bjp` predecoder to pick the next fetch PC. It presents {inst, pc, pred_pc} to decode through a valid/ready handshake, and accepts redirects from the execute/commit stage on mispredict, jalr, ecall or mret.

---
 rtl/ifu_pkg.sv | 34 +++
 rtl/ifu_bjp.sv | 27 ++
 rtl/ifu.sv | 163 ++++++++++++++++
 tb/tb_ifu.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared fetch types, FSM states and predecode helpers.
// Imported by the ifu top and its bjp predecoder.
package ifu_pkg;

  typedef logic [31:0] ysyx_23060251_pc_bus;
  typedef logic [31:0] ysyx_23060251_inst_bus;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } ifu_state_t;

  localparam ysyx_23060251_inst_bus IFU_NOP = 32'h0000_0013;

  localparam logic [6:0] OP_JAL    = 7'b110_1111;
  localparam logic [6:0] OP_BRANCH = 7'b110_0011;

  function automatic ysyx_23060251_pc_bus imm_j(
    input ysyx_23060251_inst_bus inst
  );
    return {{12{inst[31]}}, inst[19:12], inst[20],
            inst[30:21], 1'b0};
  endfunction

  function automatic ysyx_23060251_pc_bus imm_b(
    input ysyx_23060251_inst_bus inst
  );
    return {{20{inst[31]}}, inst[7], inst[30:25],
            inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/ifu_bjp.sv
// Static next-PC predecoder: jal and all branches predicted taken.
// Everything else (including jalr) falls through to pc+4.
module bjp
  import ifu_pkg::*;
(
  input  ysyx_23060251_inst_bus inst_i,
  input  ysyx_23060251_pc_bus   pc_i,
  output ysyx_23060251_pc_bus   pred_pc_o
);

  logic is_jal;
  logic is_br;

  assign is_jal = (inst_i[6:0] == OP_JAL);
  assign is_br  = (inst_i[6:0] == OP_BRANCH);

  // pick target from the immediate class of the opcode
  always_comb begin
    pred_pc_o = pc_i + 32'd4;
    unique case (1'b1)
      is_jal:  pred_pc_o = pc_i + imm_j(inst_i);
      is_br:   pred_pc_o = pc_i + imm_b(inst_i);
      default: ;
    endcase
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding imem read, bjp-predicted next PC.
// YSYX_23060251_IFU_BYPASS_EN: forward a fresh response straight to decode.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        ifu_req_valid_o,
  input  logic        ifu_req_ready_i,
  output logic [31:0] ifu_req_addr_o,
  input  logic        ifu_resp_valid_i,
  output logic        ifu_resp_ready_o,
  input  logic [31:0] ifu_resp_data_i,
  input  logic        ifu_resp_err_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_inst_o,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_pred_pc_o,
  output logic        out_fault_o
);

  ifu_state_t state;

  ysyx_23060251_pc_bus   pc;
  ysyx_23060251_pc_bus   req_addr;
  logic                  req_valid;
  logic                  resp_ready;
  logic                  kill;

  logic                  hold_valid;
  ysyx_23060251_inst_bus hold_inst;
  ysyx_23060251_pc_bus   hold_pc;
  ysyx_23060251_pc_bus   hold_pred;
  logic                  hold_fault;

  ysyx_23060251_pc_bus   bjp_pred;
  ysyx_23060251_pc_bus   rsp_pred;
  ysyx_23060251_inst_bus rsp_inst;
  logic                  rsp_fire;
  logic                  rsp_use;
  logic                  byp_fire;

  bjp u_bjp (
    .inst_i    (ifu_resp_data_i),
    .pc_i      (req_addr),
    .pred_pc_o (bjp_pred)
  );

  assign ifu_req_valid_o  = req_valid;
  assign ifu_req_addr_o   = req_addr;
  assign ifu_resp_ready_o = resp_ready;

  assign rsp_fire = resp_ready & ifu_resp_valid_i;
  assign rsp_use  = rsp_fire & ~kill & ~redirect_valid_i;
  assign rsp_inst = ifu_resp_err_i ? IFU_NOP : ifu_resp_data_i;
  assign rsp_pred = ifu_resp_err_i ? req_addr + 32'd4 : bjp_pred;

`ifdef YSYX_23060251_IFU_BYPASS_EN
  assign byp_fire      = rsp_use & out_ready_i;
  assign out_valid_o   = hold_valid | byp_fire;
  assign out_inst_o    = byp_fire ? rsp_inst : hold_inst;
  assign out_pc_o      = byp_fire ? req_addr : hold_pc;
  assign out_pred_pc_o = byp_fire ? rsp_pred : hold_pred;
  assign out_fault_o   = byp_fire ? ifu_resp_err_i : hold_fault;
`else
  assign byp_fire      = 1'b0;
  assign out_valid_o   = hold_valid;
  assign out_inst_o    = hold_inst;
  assign out_pc_o      = hold_pc;
  assign out_pred_pc_o = hold_pred;
  assign out_fault_o   = hold_fault;
`endif

  // fetch FSM: request, wait, hold; redirects override the next PC
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      req_valid  <= 1'b0;
      resp_ready <= 1'b0;
      kill       <= 1'b0;
      hold_valid <= 1'b0;
      hold_inst  <= '0;
      hold_pc    <= '0;
      hold_pred  <= '0;
      hold_fault <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state     <= REQ;
          req_valid <= 1'b1;
          req_addr  <= pc;
        end
        REQ: begin
          if (redirect_valid_i) begin
            pc   <= redirect_pc_i;
            kill <= 1'b1;
          end
          if (ifu_req_ready_i) begin
            req_valid  <= 1'b0;
            resp_ready <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_valid_i) begin
            pc <= redirect_pc_i;
          end
          if (ifu_resp_valid_i) begin
            resp_ready <= 1'b0;
            kill       <= 1'b0;
            if (redirect_valid_i) begin
              state     <= REQ;
              req_valid <= 1'b1;
              req_addr  <= redirect_pc_i;
            end else if (kill) begin
              state     <= REQ;
              req_valid <= 1'b1;
              req_addr  <= pc;
            end else if (byp_fire) begin
              state     <= REQ;
              req_valid <= 1'b1;
              pc        <= rsp_pred;
              req_addr  <= rsp_pred;
            end else begin
              state      <= HOLD;
              hold_valid <= 1'b1;
              hold_inst  <= rsp_inst;
              hold_pc    <= req_addr;
              hold_pred  <= rsp_pred;
              hold_fault <= ifu_resp_err_i;
            end
          end else if (redirect_valid_i) begin
            kill <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid_i) begin
            hold_valid <= 1'b0;
            state      <= REQ;
            req_valid  <= 1'b1;
            pc         <= redirect_pc_i;
            req_addr   <= redirect_pc_i;
          end else if (out_ready_i) begin
            hold_valid <= 1'b0;
            state      <= REQ;
            req_valid  <= 1'b1;
            pc         <= hold_pred;
            req_addr   <= hold_pred;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: predecode table plus redirect/stall sequences.
// Loop-timing expectation follows YSYX_23060251_IFU_BYPASS_EN.
module tb_ifu;

`ifdef YSYX_23060251_IFU_BYPASS_EN
  localparam int LOOP = 2;
`else
  localparam int LOOP = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid;
  logic        req_ready = 1'b1;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0;
  logic        resp_ready;
  logic [31:0] resp_data = '0;
  logic        resp_err = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pred;
  logic        out_fault;

  always #5 clk = ~clk;

  ifu dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .ifu_req_valid_o  (req_valid),
    .ifu_req_ready_i  (req_ready),
    .ifu_req_addr_o   (req_addr),
    .ifu_resp_valid_i (resp_valid),
    .ifu_resp_ready_o (resp_ready),
    .ifu_resp_data_i  (resp_data),
    .ifu_resp_err_i   (resp_err),
    .redirect_valid_i (redir),
    .redirect_pc_i    (redir_pc),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_inst_o       (out_inst),
    .out_pc_o         (out_pc),
    .out_pred_pc_o    (out_pred),
    .out_fault_o      (out_fault)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic        err;
    logic [31:0] inst;
    logic [31:0] pred;
    logic        fault;
  } vec_t;

  vec_t tbl[9];

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int stall_cfg = 0;

  logic [31:0] req_q[$];
  int          req_cyc[$];
  logic [31:0] opc_q[$];
  logic [31:0] oinst_q[$];
  logic [31:0] opred_q[$];
  logic        ofault_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic lookup(input logic [31:0] a, output logic [31:0] w,
                        output logic e);
    w = 32'h0000_0013;
    e = 1'b0;
    for (int i = 0; i < 9; i++)
      if (tbl[i].pc == a) begin
        w = tbl[i].word;
        e = tbl[i].err;
      end
  endtask

  // memory model and handshake monitor
  initial begin : mem
    logic        rst_s, hs_req, hs_rsp, dec;
    logic [31:0] a_s, paddr, w;
    logic        pend, e;
    int          cnt;
    pend = 1'b0;
    paddr = '0;
    cnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      rst_s  = rst_n;
      a_s    = req_addr;
      hs_req = rst_n && req_valid && req_ready;
      hs_rsp = rst_n && resp_valid && resp_ready;
      dec    = rst_n && req_valid && !req_ready && cnt > 0;
      if (hs_req) begin
        req_q.push_back(req_addr);
        req_cyc.push_back(cyc);
      end
      if (rst_n && out_valid && out_ready && !redir) begin
        opc_q.push_back(out_pc);
        oinst_q.push_back(out_inst);
        opred_q.push_back(out_pred);
        ofault_q.push_back(out_fault);
      end
      @(posedge clk);
      #1;
      if (!rst_s) begin
        pend = 1'b0;
        cnt = stall_cfg;
      end else if (hs_req) begin
        pend = 1'b1;
        paddr = a_s;
        cnt = stall_cfg;
      end else if (hs_rsp) begin
        pend = 1'b0;
      end
      if (dec) cnt--;
      req_ready = (cnt == 0);
      lookup(paddr, w, e);
      resp_valid = pend;
      resp_data = pend ? w : 32'h0;
      resp_err = pend ? e : 1'b0;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    redir = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_reqs(input int n, input string nm);
    int k;
    k = 0;
    while (req_q.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (req_q.size() < n) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_outs(input int n, input string nm);
    int k;
    k = 0;
    while (opc_q.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (opc_q.size() < n) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin : seq
    int rb, ob, k, bad;
    tbl[0] = '{32'h8000_0000, 32'h0000_0013, 1'b0,
               32'h0000_0013, 32'h8000_0004, 1'b0};
    tbl[1] = '{32'h8000_0004, 32'h0000_0013, 1'b0,
               32'h0000_0013, 32'h8000_0008, 1'b0};
    tbl[2] = '{32'h8000_0008, 32'h0000_0463, 1'b0,
               32'h0000_0463, 32'h8000_0010, 1'b0};
    tbl[3] = '{32'h8000_0010, 32'h0100_006F, 1'b0,
               32'h0100_006F, 32'h8000_0020, 1'b0};
    tbl[4] = '{32'h8000_0020, 32'h0000_8067, 1'b0,
               32'h0000_8067, 32'h8000_0024, 1'b0};
    tbl[5] = '{32'h8000_0024, 32'h01C0_006F, 1'b0,
               32'h01C0_006F, 32'h8000_0040, 1'b0};
    tbl[6] = '{32'h8000_0040, 32'hDEAD_BEEF, 1'b1,
               32'h0000_0013, 32'h8000_0044, 1'b1};
    tbl[7] = '{32'h8000_0044, 32'hFE00_08E3, 1'b0,
               32'hFE00_08E3, 32'h8000_0034, 1'b0};
    tbl[8] = '{32'h8000_0034, 32'h0000_0013, 1'b0,
               32'h0000_0013, 32'h8000_0038, 1'b0};

    // reset values, stalled request stability, redirect in REQ
    stall_cfg = 3;
    do_reset();
    @(negedge clk);
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_req_addr", req_addr, 32'h8000_0000);
    chk("rst_resp_ready", {31'd0, resp_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_pred", out_pred, 32'd0);
    chk("rst_out_fault", {31'd0, out_fault}, 32'd0);
    release_reset();
    rb = req_q.size();
    ob = opc_q.size();
    @(negedge clk);
    chk("idle_no_req", {31'd0, req_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", i), {31'd0, req_valid}, 32'd1);
      chk($sformatf("stall%0d_addr", i), req_addr, 32'h8000_0000);
      if (i == 1) begin
        redir_pc = 32'h8000_0300;
        redir = 1'b1;
      end
      if (i == 2) redir = 1'b0;
    end
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    stall_cfg = 0;
    wait_reqs(rb + 2, "req_redir");
    if (req_q.size() >= rb + 2) begin
      chk("inflight_addr", req_q[rb], 32'h8000_0000);
      chk("req_after_redir_req", req_q[rb + 1], 32'h8000_0300);
    end
    wait_outs(ob + 1, "out_redir");
    if (opc_q.size() > ob)
      chk("killed_resp_dropped", opc_q[ob], 32'h8000_0300);

    // predecode table with zero-wait memory and ready decode
    do_reset();
    release_reset();
    rb = req_q.size();
    ob = opc_q.size();
    wait_outs(ob + 9, "table");
    wait_reqs(rb + 9, "table_req");
    if (opc_q.size() >= ob + 9 && req_q.size() >= rb + 9) begin
      for (int i = 0; i < 9; i++) begin
        chk($sformatf("t%0d_req", i), req_q[rb + i], tbl[i].pc);
        chk($sformatf("t%0d_pc", i), opc_q[ob + i], tbl[i].pc);
        chk($sformatf("t%0d_inst", i), oinst_q[ob + i], tbl[i].inst);
        chk($sformatf("t%0d_pred", i), opred_q[ob + i], tbl[i].pred);
        chk($sformatf("t%0d_fault", i), {31'd0, ofault_q[ob + i]},
            {31'd0, tbl[i].fault});
      end
      chk("loop_cycles", req_cyc[rb + 1] - req_cyc[rb], LOOP);
    end

    // redirect while waiting on 0x80000008
    do_reset();
    release_reset();
    k = 0;
    while (!(resp_ready && req_addr == 32'h8000_0008) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("found_wait_08", {31'd0, resp_ready}, 32'd1);
    #1;
    rb = req_q.size();
    ob = opc_q.size();
    redir_pc = 32'h8000_0100;
    redir = 1'b1;
    #1;
    chk("wait_redir_no_out", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    redir = 1'b0;
    wait_reqs(rb + 1, "wait_redir");
    if (req_q.size() > rb)
      chk("wait_redir_req", req_q[rb], 32'h8000_0100);
    wait_outs(ob + 1, "wait_redir_out");
    if (opc_q.size() > ob)
      chk("wait_redir_out_pc", opc_q[ob], 32'h8000_0100);

    // decode stalls in HOLD, then redirect drops the held entry
    @(negedge clk);
    out_ready = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("hold_reached", {31'd0, out_valid}, 32'd1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (req_valid || !out_valid) bad++;
    end
    chk("hold_stall_quiet", bad, 32'd0);
    #1;
    rb = req_q.size();
    ob = opc_q.size();
    redir_pc = 32'h8000_0200;
    redir = 1'b1;
    @(negedge clk);
    redir = 1'b0;
    out_ready = 1'b1;
    wait_reqs(rb + 1, "hold_redir");
    if (req_q.size() > rb)
      chk("hold_redir_req", req_q[rb], 32'h8000_0200);
    wait_outs(ob + 1, "hold_redir_out");
    if (opc_q.size() > ob)
      chk("hold_dropped", opc_q[ob], 32'h8000_0200);

    // PC wrap at the top of the address space
    @(negedge clk);
    #1;
    rb = req_q.size();
    ob = opc_q.size();
    redir_pc = 32'hFFFF_FFFC;
    redir = 1'b1;
    @(negedge clk);
    redir = 1'b0;
    wait_outs(ob + 1, "wrap");
    wait_reqs(rb + 2, "wrap_req");
    if (opc_q.size() > ob) begin
      chk("wrap_pc", opc_q[ob], 32'hFFFF_FFFC);
      chk("wrap_pred", opred_q[ob], 32'h0000_0000);
    end
    if (req_q.size() >= rb + 2) begin
      chk("wrap_req0", req_q[rb], 32'hFFFF_FFFC);
      chk("wrap_req1", req_q[rb + 1], 32'h0000_0000);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
